// File: rtl/mips_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// mips_trace_buffer_if : valid/ready readout channel of the trace FIFO
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mips_trace_buffer_if;
  logic        trace_valid;
  logic        trace_ready;
  logic [23:0] trace_data;

  modport master (
    output trace_valid,
    output trace_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_data,
    output trace_ready
  );
endinterface

`default_nettype wire

// File: rtl/mips_trace_buffer.sv
// ----------------------------------------------------------------------------
// mips_trace_buffer : Soc_Mips writeback/exception trace capture FIFO with
//                     overflow trigger and post-trigger freeze
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int POST_COUNT = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   cpu_step,
  input  wire logic                   arm,
  input  wire logic                   writes_only,
  input  wire logic [5:0]             PCout,
  input  wire logic [7:0]             WriteBack,
  input  wire logic [2:0]             MEMWB_RegisterRd,
  input  wire logic [1:0]             MEMWB_ControlSignals,
  input  wire logic                   Overflow,
  input  wire logic [2:0]             ExceptionCause,
  input  wire logic [5:0]             ExceptionPC,
  mips_trace_buffer_if.master         trace,
  output logic [$clog2(DEPTH):0]      level,
  output logic [7:0]                  dropped,
  output logic [1:0]                  state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] c_full = LW'(DEPTH);
  localparam logic [7:0]    c_post = 8'(POST_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_post_cnt;
  logic [7:0]    w_post_nxt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_dropped;
  logic          r_drop_pend;
  logic [23:0]   r_mem [DEPTH];

  logic          w_regwrite;
  logic          w_capturing;
  logic          w_rec;
  logic          w_valid;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_trigger;
  logic [23:0]   w_entry;
  logic          w_unused_ctrl;

  assign w_regwrite    = MEMWB_ControlSignals[1];
  assign w_unused_ctrl = MEMWB_ControlSignals[0];

  // A step coinciding with arm belongs to the flushed session, so it is dropped silently.
  assign w_capturing = (r_state == S_CAPTURE) || (r_state == S_POST);
  assign w_rec       = cpu_step && !arm && w_capturing &&
                       (!writes_only || w_regwrite || Overflow);
  assign w_valid     = (r_level != '0);
  assign w_pop       = w_valid && trace.trace_ready && !arm;
  assign w_full      = (r_level == c_full);
  assign w_push      = w_rec && (!w_full || w_pop);
  assign w_drop      = w_rec && w_full && !w_pop;
  assign w_trigger   = w_rec && (r_state == S_CAPTURE) && Overflow;

  assign w_entry = {(w_trigger ? ExceptionPC : PCout), MEMWB_RegisterRd, WriteBack,
                    ExceptionCause, Overflow, w_regwrite, w_trigger, r_drop_pend};

  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post_cnt;
    if (arm) begin
      w_state_nxt = S_CAPTURE;
      w_post_nxt  = 8'd0;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          if (w_trigger) begin
            w_post_nxt  = c_post;
            w_state_nxt = (c_post == 8'd0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          // Discarded (full) entries still consume the post-trigger budget.
          if (w_rec) begin
            w_post_nxt = r_post_cnt - 8'd1;
            if (r_post_cnt == 8'd1) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_post_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_post_cnt <= w_post_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_dropped   <= 8'd0;
      r_drop_pend <= 1'b0;
    end else if (arm) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_dropped   <= 8'd0;
      r_drop_pend <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        if (r_dropped != 8'hFF) begin
          r_dropped <= r_dropped + 8'd1;
        end
        r_drop_pend <= 1'b1;
      end else if (w_push) begin
        r_drop_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // No bypass: an empty FIFO presents zero even if a push is in flight.
  assign trace.trace_valid = w_valid;
  assign trace.trace_data  = w_valid ? r_mem[r_rd_ptr] : 24'd0;
  assign level             = r_level;
  assign dropped           = r_dropped;
  assign state             = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_mips_trace_buffer : directed vector bench for mips_trace_buffer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mips_trace_buffer;

  logic       clk;
  logic       rst;
  logic       cpu_step;
  logic       arm;
  logic       writes_only;
  logic [5:0] PCout;
  logic [7:0] WriteBack;
  logic [2:0] MEMWB_RegisterRd;
  logic [1:0] MEMWB_ControlSignals;
  logic       Overflow;
  logic [2:0] ExceptionCause;
  logic [5:0] ExceptionPC;
  logic [4:0] level;
  logic [7:0] dropped;
  logic [1:0] state;

  mips_trace_buffer_if tr_if ();

  mips_trace_buffer #(.DEPTH(16), .POST_COUNT(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cpu_step             (cpu_step),
    .arm                  (arm),
    .writes_only          (writes_only),
    .PCout                (PCout),
    .WriteBack            (WriteBack),
    .MEMWB_RegisterRd     (MEMWB_RegisterRd),
    .MEMWB_ControlSignals (MEMWB_ControlSignals),
    .Overflow             (Overflow),
    .ExceptionCause       (ExceptionCause),
    .ExceptionPC          (ExceptionPC),
    .trace                (tr_if.master),
    .level                (level),
    .dropped              (dropped),
    .state                (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        step;
    logic        arm;
    logic        wo;
    logic [5:0]  pc;
    logic [7:0]  wb;
    logic [2:0]  rd;
    logic        rw;
    logic        ovf;
    logic [2:0]  cause;
    logic [5:0]  epc;
    logic        ready;
    logic [4:0]  lvl;
    logic        vld;
    logic [23:0] data;
    logic [1:0]  st;
  } vec_t;

  vec_t vt [25];

  function automatic logic [23:0] ent(input logic [5:0] pc, input logic [2:0] rd,
                                      input logic [7:0] wb, input logic [2:0] cause,
                                      input logic ovf, input logic rw,
                                      input logic trig, input logic drp);
    return {pc, rd, wb, cause, ovf, rw, trig, drp};
  endfunction

  function automatic vec_t v(input logic step, input logic a, input logic wo,
                             input logic [5:0] pc, input logic [7:0] wb, input logic [2:0] rd,
                             input logic rw, input logic ovf, input logic [2:0] cause,
                             input logic [5:0] epc, input logic ready, input logic [4:0] lvl,
                             input logic vld, input logic [23:0] data, input logic [1:0] st);
    vec_t r;
    r.step = step; r.arm = a; r.wo = wo; r.pc = pc; r.wb = wb; r.rd = rd;
    r.rw = rw; r.ovf = ovf; r.cause = cause; r.epc = epc; r.ready = ready;
    r.lvl = lvl; r.vld = vld; r.data = data; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic step, input logic a, input logic wo,
                       input logic [5:0] pc, input logic [7:0] wb, input logic [2:0] rd,
                       input logic rw, input logic ovf, input logic [2:0] cause,
                       input logic [5:0] epc, input logic ready);
    cpu_step             = step;
    arm                  = a;
    writes_only          = wo;
    PCout                = pc;
    WriteBack            = wb;
    MEMWB_RegisterRd     = rd;
    MEMWB_ControlSignals = {rw, 1'b0};
    Overflow             = ovf;
    ExceptionCause       = cause;
    ExceptionPC          = epc;
    tr_if.trace_ready    = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ready);
    drive(0, 0, 0, 6'd0, 8'd0, 3'd0, 0, 0, 3'd0, 6'd0, ready);
  endtask

  logic [23:0] e0, e1, e2, e10, e13, e20, et, e22, e23, exp_head;

  initial begin
    rst = 1'b0;
    idle(0);
    e0  = ent(6'd0,  3'd1, 8'h05, 3'd0, 0, 1, 0, 0);
    e1  = ent(6'd1,  3'd2, 8'h0A, 3'd0, 0, 1, 0, 0);
    e2  = ent(6'd2,  3'd3, 8'h0F, 3'd0, 0, 1, 0, 0);
    e10 = ent(6'd10, 3'd4, 8'h11, 3'd0, 0, 1, 0, 0);
    e13 = ent(6'd13, 3'd5, 8'h22, 3'd0, 0, 1, 0, 0);
    e20 = ent(6'd20, 3'd0, 8'h30, 3'd0, 0, 0, 0, 0);
    et  = ent(6'd9,  3'd6, 8'h40, 3'd1, 1, 0, 1, 0);
    e22 = ent(6'd22, 3'd7, 8'h41, 3'd1, 1, 1, 0, 0);
    e23 = ent(6'd23, 3'd1, 8'h42, 3'd0, 0, 1, 0, 0);

    //           step arm wo pc     wb     rd   rw ovf cause epc  rdy lvl vld data st
    vt[0]  = v(0, 1, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 0, 5'd0, 0, 24'd0, 2'b01);
    vt[1]  = v(1, 0, 0, 6'd0,  8'h05, 3'd1, 1, 0, 3'd0, 6'd0, 0, 5'd1, 1, e0,    2'b01);
    vt[2]  = v(1, 0, 0, 6'd1,  8'h0A, 3'd2, 1, 0, 3'd0, 6'd0, 0, 5'd2, 1, e0,    2'b01);
    vt[3]  = v(1, 0, 0, 6'd2,  8'h0F, 3'd3, 1, 0, 3'd0, 6'd0, 0, 5'd3, 1, e0,    2'b01);
    vt[4]  = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd2, 1, e1,    2'b01);
    vt[5]  = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd1, 1, e2,    2'b01);
    vt[6]  = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd0, 0, 24'd0, 2'b01);
    vt[7]  = v(1, 1, 1, 6'd5,  8'h55, 3'd1, 1, 0, 3'd0, 6'd0, 0, 5'd0, 0, 24'd0, 2'b01);
    vt[8]  = v(1, 0, 1, 6'd10, 8'h11, 3'd4, 1, 0, 3'd0, 6'd0, 0, 5'd1, 1, e10,   2'b01);
    vt[9]  = v(1, 0, 1, 6'd11, 8'h12, 3'd0, 0, 0, 3'd0, 6'd0, 0, 5'd1, 1, e10,   2'b01);
    vt[10] = v(1, 0, 1, 6'd12, 8'h13, 3'd0, 0, 0, 3'd0, 6'd0, 0, 5'd1, 1, e10,   2'b01);
    vt[11] = v(1, 0, 1, 6'd13, 8'h22, 3'd5, 1, 0, 3'd0, 6'd0, 0, 5'd2, 1, e10,   2'b01);
    vt[12] = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd1, 1, e13,   2'b01);
    vt[13] = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd0, 0, 24'd0, 2'b01);
    vt[14] = v(0, 1, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 0, 5'd0, 0, 24'd0, 2'b01);
    vt[15] = v(1, 0, 0, 6'd20, 8'h30, 3'd0, 0, 0, 3'd0, 6'd0, 0, 5'd1, 1, e20,   2'b01);
    vt[16] = v(1, 0, 0, 6'd21, 8'h40, 3'd6, 0, 1, 3'd1, 6'd9, 0, 5'd2, 1, e20,   2'b10);
    vt[17] = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd1, 1, et,    2'b10);
    vt[18] = v(1, 0, 0, 6'd22, 8'h41, 3'd7, 1, 1, 3'd1, 6'd9, 0, 5'd2, 1, et,    2'b10);
    vt[19] = v(1, 0, 1, 6'd50, 8'h50, 3'd2, 0, 0, 3'd0, 6'd0, 0, 5'd2, 1, et,    2'b10);
    vt[20] = v(1, 0, 0, 6'd23, 8'h42, 3'd1, 1, 0, 3'd0, 6'd0, 0, 5'd3, 1, et,    2'b11);
    vt[21] = v(1, 0, 0, 6'd24, 8'h43, 3'd2, 1, 0, 3'd0, 6'd0, 0, 5'd3, 1, et,    2'b11);
    vt[22] = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd2, 1, e22,   2'b11);
    vt[23] = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd1, 1, e23,   2'b11);
    vt[24] = v(0, 0, 0, 6'd0,  8'h00, 3'd0, 0, 0, 3'd0, 6'd0, 1, 5'd0, 0, 24'd0, 2'b11);

    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_valid", 32'(tr_if.trace_valid), 32'd0);
    chk("reset_data", 32'(tr_if.trace_data), 32'd0);
    chk("reset_dropped", 32'(dropped), 32'd0);
    chk("reset_state", 32'(state), 32'd0);

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].step, vt[i].arm, vt[i].wo, vt[i].pc, vt[i].wb, vt[i].rd,
            vt[i].rw, vt[i].ovf, vt[i].cause, vt[i].epc, vt[i].ready);
      tick();
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("v%0d_valid", i), 32'(tr_if.trace_valid), 32'(vt[i].vld));
      chk($sformatf("v%0d_data", i), 32'(tr_if.trace_data), 32'(vt[i].data));
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("v%0d_dropped", i), 32'(dropped), 32'd0);
    end

    // Overfill: 20 records into 16 slots.
    drive(0, 1, 0, 6'd0, 8'd0, 3'd0, 0, 0, 3'd0, 6'd0, 0);
    tick();
    chk("rearm_level", 32'(level), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 6'(i), 8'(i), 3'(i), 1, 0, 3'd0, 6'd0, 0);
      tick();
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_dropped", 32'(dropped), 32'd4);
    chk("full_head", 32'(tr_if.trace_data), 32'(ent(6'd0, 3'd0, 8'd0, 3'd0, 0, 1, 0, 0)));
    idle(1);
    tick();
    chk("pop1_level", 32'(level), 32'd15);
    chk("pop1_head", 32'(tr_if.trace_data), 32'(ent(6'd1, 3'd1, 8'd1, 3'd0, 0, 1, 0, 0)));
    drive(1, 0, 0, 6'd30, 8'h30, 3'd2, 1, 0, 3'd0, 6'd0, 0);
    tick();
    chk("refill_level", 32'(level), 32'd16);
    chk("refill_dropped", 32'(dropped), 32'd4);
    // Push and pop together at full.
    drive(1, 0, 0, 6'd31, 8'h31, 3'd3, 1, 0, 3'd0, 6'd0, 1);
    tick();
    chk("pushpop_level", 32'(level), 32'd16);
    chk("pushpop_dropped", 32'(dropped), 32'd4);
    chk("pushpop_head", 32'(tr_if.trace_data), 32'(ent(6'd2, 3'd2, 8'd2, 3'd0, 0, 1, 0, 0)));
    idle(1);
    for (int k = 0; k < 16; k++) begin
      if (k < 14)
        exp_head = ent(6'(k + 2), 3'(k + 2), 8'(k + 2), 3'd0, 0, 1, 0, 0);
      else if (k == 14)
        exp_head = ent(6'd30, 3'd2, 8'h30, 3'd0, 0, 1, 0, 1);
      else
        exp_head = ent(6'd31, 3'd3, 8'h31, 3'd0, 0, 1, 0, 0);
      chk($sformatf("drain%0d_data", k), 32'(tr_if.trace_data), 32'(exp_head));
      tick();
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(tr_if.trace_valid), 32'd0);

    // Asynchronous reset while in POST with five entries held.
    drive(0, 1, 0, 6'd0, 8'd0, 3'd0, 0, 0, 3'd0, 6'd0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 6'(40 + i), 8'(i), 3'(i), 1, 0, 3'd0, 6'd0, 0);
      tick();
    end
    drive(1, 0, 0, 6'd44, 8'h44, 3'd4, 1, 1, 3'd2, 6'd9, 0);
    tick();
    chk("post_level", 32'(level), 32'd5);
    chk("post_state", 32'(state), 32'd2);
    idle(0);
    rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_valid", 32'(tr_if.trace_valid), 32'd0);
    chk("async_data", 32'(tr_if.trace_data), 32'd0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 6'(50 + i), 8'(i), 3'd1, 1, 0, 3'd0, 6'd0, 0);
      tick();
    end
    chk("postrst_level", 32'(level), 32'd0);
    chk("postrst_state", 32'(state), 32'd0);
    drive(0, 1, 0, 6'd0, 8'd0, 3'd0, 0, 0, 3'd0, 6'd0, 0);
    tick();
    drive(1, 0, 0, 6'd60, 8'h66, 3'd6, 1, 0, 3'd0, 6'd0, 0);
    tick();
    chk("rearm2_level", 32'(level), 32'd1);
    chk("rearm2_state", 32'(state), 32'd1);
    chk("rearm2_data", 32'(tr_if.trace_data), 32'(ent(6'd60, 3'd6, 8'h66, 3'd0, 0, 1, 0, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
